// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared field widths and helpers for the data SRAM responder
package data_sram_responder_pkg;

    // Response-channel field widths shared by the responder and its queue.
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int SIZE_W = 2;
    localparam int ADDR_W = 32;

    // Write completions carry no data; reads carry whatever the RAM returned.
    function automatic logic [DATA_W-1:0] resp_word(input logic is_wr,
                                                    input logic [DATA_W-1:0] rd);
        return is_wr ? '0 : rd;
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// rtl/data_sram_responder_resp_fifo.sv - in-order response queue
// Ports: clk/reset (sync, active-high); push/push_data write the tail;
// pop retires the head; head is the oldest entry; empty/count report occupancy.
module resp_fifo
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // Explicit wrap so non-power-of-two pointer widths stay correct too.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data_sram slave driving a 1-cycle synchronous RAM
// Ports: clk/reset (sync, active-high); data_sram_* request/response channel
// (req/wr/size/wstrb/addr/wdata in, addr_ok/data_ok/rdata out);
// ram_* word-addressed RAM port (en/we/addr/wdata out, rdata in one cycle after en).
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int RESP_LAT  = 0,
    parameter int RAM_AW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_sram_req,
    input  logic                data_sram_wr,
    input  logic [SIZE_W-1:0]   data_sram_size,
    input  logic [STRB_W-1:0]   data_sram_wstrb,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic                data_sram_addr_ok,
    output logic                data_sram_data_ok,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                ram_en,
    output logic [STRB_W-1:0]   ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int OCW = $clog2(MAX_OUTST + 1);

    logic [OCW-1:0]    outst_cnt;
    logic              ret_v;
    logic              ret_wr;
    logic [3:0]        hd_cnt;
    logic              accept;
    logic              q_push;
    logic              q_pop;
    logic              q_empty;
    logic [OCW-1:0]    q_count;
    logic [DATA_W-1:0] q_head;
    logic              new_head;

    // outst_cnt covers the return slot and the queue, so it also keeps the
    // queue from ever overflowing.
    assign data_sram_addr_ok = ~reset & (outst_cnt < OCW'(MAX_OUTST));
    assign accept            = data_sram_req & data_sram_addr_ok;

    assign ram_en    = accept;
    assign ram_we    = accept ? ({STRB_W{data_sram_wr}} & data_sram_wstrb) : '0;
    assign ram_addr  = data_sram_addr[RAM_AW+1:2];
    assign ram_wdata = data_sram_wdata;

    assign q_push = ret_v;

    assign data_sram_data_ok = ~reset & ~q_empty & (hd_cnt == 4'd0);
    assign data_sram_rdata   = data_sram_data_ok ? q_head : '0;
    assign q_pop             = data_sram_data_ok;

    // A fresh head appears on a push into an empty queue, or on a pop that
    // leaves something behind (including the entry pushed in the same cycle).
    assign new_head = (q_push & q_empty) |
                      (q_pop & ((q_count > OCW'(1)) | q_push));

    resp_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (resp_word(ret_wr, ram_rdata)),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ret_v     <= 1'b0;
            ret_wr    <= 1'b0;
            hd_cnt    <= 4'd0;
            outst_cnt <= '0;
        end else begin
            ret_v  <= accept;
            ret_wr <= data_sram_wr;

            if (new_head) begin
                hd_cnt <= 4'(RESP_LAT);
            end else if (!q_empty && hd_cnt != 4'd0) begin
                hd_cnt <= hd_cnt - 4'd1;
            end

            if (accept && !q_pop) begin
                outst_cnt <= outst_cnt + 1'b1;
            end else if (q_pop && !accept) begin
                outst_cnt <= outst_cnt - 1'b1;
            end
        end
    end

    // Size is informational and the low/high address bits are not part of
    // the word address; fold them so they are visibly consumed.
    logic unused_bits;
    if (RAM_AW < 30) begin : g_hi_bits
        assign unused_bits = ^{data_sram_size, data_sram_addr[1:0],
                               data_sram_addr[ADDR_W-1:RAM_AW+2]};
    end else begin : g_no_hi_bits
        assign unused_bits = ^{data_sram_size, data_sram_addr[1:0]};
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - self-checking bench for data_sram_responder
module tb_data_sram_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req;
    logic        req_b;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        a_addr_ok, a_data_ok, a_ram_en;
    logic [31:0] a_rdata, a_ram_wdata, a_ram_rdata;
    logic [3:0]  a_ram_we;
    logic [15:0] a_ram_addr;

    logic        b_addr_ok, b_data_ok, b_ram_en;
    logic [31:0] b_rdata, b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_ram_we;
    logic [15:0] b_ram_addr;

    data_sram_responder #(.MAX_OUTST(2), .RESP_LAT(0), .RAM_AW(16)) dut_a (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (a_addr_ok),
        .data_sram_data_ok (a_data_ok),
        .data_sram_rdata   (a_rdata),
        .ram_en            (a_ram_en),
        .ram_we            (a_ram_we),
        .ram_addr          (a_ram_addr),
        .ram_wdata         (a_ram_wdata),
        .ram_rdata         (a_ram_rdata)
    );

    data_sram_responder #(.MAX_OUTST(2), .RESP_LAT(3), .RAM_AW(16)) dut_b (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req_b),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (b_addr_ok),
        .data_sram_data_ok (b_data_ok),
        .data_sram_rdata   (b_rdata),
        .ram_en            (b_ram_en),
        .ram_we            (b_ram_we),
        .ram_addr          (b_ram_addr),
        .ram_wdata         (b_ram_wdata),
        .ram_rdata         (b_ram_rdata)
    );

    function automatic logic [31:0] init_word(input int w);
        if (w == 16) return 32'hDEADBEEF;
        return (32'(w) * 32'h01010101) ^ 32'hA5A5A5A5;
    endfunction

    // Synchronous RAMs with one-cycle read latency, one per DUT.
    logic [31:0] ram_a [0:255];
    logic [31:0] ram_b [0:255];
    logic        ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int w = 0; w < 256; w++) begin
                ram_a[w] <= init_word(w);
                ram_b[w] <= init_word(w);
            end
            ram_ready <= 1'b1;
        end else begin
            if (a_ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (a_ram_we[b]) ram_a[a_ram_addr[7:0]][8*b +: 8] <= a_ram_wdata[8*b +: 8];
                a_ram_rdata <= ram_a[a_ram_addr[7:0]];
            end
            if (b_ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (b_ram_we[b]) ram_b[b_ram_addr[7:0]][8*b +: 8] <= b_ram_wdata[8*b +: 8];
                b_ram_rdata <= ram_b[b_ram_addr[7:0]];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rq, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        reset = r;
        req   = rq;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
    endtask

    typedef struct {
        logic        rst;
        logic        rq;
        logic        w;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic        ao;
        logic        en;
        logic [3:0]  we;
        logic        dok;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rq, input logic w, input logic [3:0] s,
                                input logic [31:0] a, input logic [31:0] d, input logic ao,
                                input logic en, input logic [3:0] we, input logic dok,
                                input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.rq = rq; v.w = w; v.s = s; v.a = a; v.d = d;
        v.ao = ao; v.en = en; v.we = we; v.dok = dok; v.rd = rd;
        return v;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    localparam int LAT_A = 0;
    localparam int MAX_A = 2;

    initial begin
        vec_t        tbl[$];
        pend_t       pend[$];
        pend_t       p;
        logic [31:0] ref_mem [0:255];
        int          last_due;
        int          cyc;
        int          b_hits[$];
        logic [31:0] b_data[$];
        logic        r, rq, w, exp_ao, exp_dok, exp_en;
        logic [3:0]  s, exp_we;
        logic [31:0] a, d;
        logic [7:0]  word;

        size  = 2'b10;
        req_b = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset, single read, byte write + read back, outstanding limit, reset mid-flight.
        tbl.push_back(mk(1, 1, 1, 4'hF, 32'h40, 32'h12345678, 0, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 4'h0, 32'h00, 32'h0,        0, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0,        1, 1, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 1, 4'h2, 32'h41, 32'h0000AB00, 1, 1, 4'h2, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0,        1, 1, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        0, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 1, 32'hDEADABEF));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h80, 32'h0,        1, 1, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h84, 32'h0,        1, 1, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h88, 32'h0,        0, 0, 4'h0, 1, init_word(32)));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h88, 32'h0,        1, 1, 4'h0, 1, init_word(33)));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h8C, 32'h0,        1, 1, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h90, 32'h0,        0, 0, 4'h0, 1, init_word(34)));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 1, init_word(35)));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 32'h40, 32'h0,        1, 1, 4'h0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 4'h0, 32'h00, 32'h0,        0, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h00, 32'h0,        1, 0, 4'h0, 0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rq, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d);
            @(negedge clk);
            check($sformatf("vec%0d addr_ok", i),  32'(a_addr_ok),  32'(tbl[i].ao));
            check($sformatf("vec%0d ram_en", i),   32'(a_ram_en),   32'(tbl[i].en));
            check($sformatf("vec%0d ram_we", i),   32'(a_ram_we),   32'(tbl[i].we));
            check($sformatf("vec%0d ram_addr", i), 32'(a_ram_addr), 32'(tbl[i].a[17:2]));
            check($sformatf("vec%0d data_ok", i),  32'(a_data_ok),  32'(tbl[i].dok));
            check($sformatf("vec%0d rdata", i),    a_rdata,         tbl[i].rd);
            @(posedge clk);
            #1;
        end
        check("outst_cnt after reset", 32'(dut_a.outst_cnt), 32'd0);

        // RESP_LAT=3: reads accepted at T and T+1 answer at T+5 and T+9.
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0);
        for (int k = 0; k < 14; k++) begin
            req_b = (k < 2);
            addr  = (k == 0) ? 32'h40 : 32'h80;
            @(negedge clk);
            if (k < 2) check($sformatf("lat addr_ok T+%0d", k), 32'(b_addr_ok), 32'd1);
            if (k == 2) check("lat addr_ok T+2", 32'(b_addr_ok), 32'd0);
            if (b_data_ok) begin
                b_hits.push_back(k);
                b_data.push_back(b_rdata);
            end
            @(posedge clk);
            #1;
        end
        req_b = 1'b0;
        check("lat response count", 32'(b_hits.size()), 32'd2);
        if (b_hits.size() == 2) begin
            check("lat first data_ok cycle",  32'(b_hits[0]), 32'd5);
            check("lat second data_ok cycle", 32'(b_hits[1]), 32'd9);
            check("lat first rdata",  b_data[0], 32'hDEADBEEF);
            check("lat second rdata", b_data[1], init_word(32));
        end

        // Randomized traffic against an occupancy/due-time reference model.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int wi = 0; wi < 256; wi++) ref_mem[wi] = ram_a[wi];
        last_due = -100;
        cyc = 0;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            rq = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            s  = 4'($urandom);
            a  = {22'd0, 8'($urandom), 2'($urandom)};
            d  = $urandom;
            drive(r, rq, w, s, a, d);
            @(negedge clk);
            exp_ao  = !r && (pend.size() < MAX_A);
            exp_dok = !r && (pend.size() > 0) && (pend[0].due == cyc);
            exp_en  = rq && exp_ao;
            exp_we  = (exp_en && w) ? s : 4'h0;
            check($sformatf("rnd%0d addr_ok", i),  32'(a_addr_ok),  32'(exp_ao));
            check($sformatf("rnd%0d data_ok", i),  32'(a_data_ok),  32'(exp_dok));
            check($sformatf("rnd%0d ram_en", i),   32'(a_ram_en),   32'(exp_en));
            check($sformatf("rnd%0d ram_we", i),   32'(a_ram_we),   32'(exp_we));
            check($sformatf("rnd%0d ram_addr", i), 32'(a_ram_addr), 32'(a[17:2]));
            if (exp_dok) check($sformatf("rnd%0d rdata", i), a_rdata, pend[0].data);
            if (r) begin
                pend.delete();
                last_due = -100;
            end else begin
                if (exp_dok) void'(pend.pop_front());
                if (exp_en) begin
                    word   = a[9:2];
                    p.data = w ? 32'h0 : ref_mem[word];
                    if (w)
                        for (int b = 0; b < 4; b++)
                            if (s[b]) ref_mem[word][8*b +: 8] = d[8*b +: 8];
                    p.due    = ((cyc + 2 > last_due + 1) ? cyc + 2 : last_due + 1) + LAT_A;
                    last_due = p.due;
                    pend.push_back(p);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
